// File: rtl/record_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module     : record_byte_streamer
// Description: Buffers 44-bit click records in a FIFO, flags drops on overflow,
//              and streams each record as 6 bytes (LSB first) on valid/ready.
// Revision   : 1.0 - initial release
// ============================================================================
module record_byte_streamer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          data_rdy,
   input  logic [43:0]   data,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   fifo_level,
   output logic [15:0]   lost_count,
   input  logic          clear_lost
);

   localparam int          c_RW    = 45;
   localparam logic [AW:0] c_FULL  = (AW+1)'(DEPTH);
   localparam logic [2:0]  c_LAST  = 3'd5;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   logic [c_RW-1:0] r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_level;
   logic            r_lost_pending;
   logic [15:0]     r_lost_count;
   state_t          r_state;
   logic [2:0]      r_idx;
   logic [47:0]     r_shift;
   logic            r_out_valid;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_drop;
   logic w_hs;
   logic w_last;
   logic w_pop;

   // Full is judged on the pre-edge level, so a same-cycle pop never rescues a push.
   assign w_full  = (r_level == c_FULL);
   assign w_empty = (r_level == '0);
   assign w_push  = data_rdy & ~w_full;
   assign w_drop  = data_rdy & w_full;
   assign w_hs    = r_out_valid & out_ready;
   assign w_last  = (r_idx == c_LAST);
   assign w_pop   = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_SEND) & w_hs & w_last));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_lost_pending, data};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_lost_pending <= 1'b0;
         r_lost_count   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr       <= r_wr_ptr + 1'b1;
            r_lost_pending <= 1'b0;
         end else if (w_drop) begin
            r_lost_pending <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (clear_lost) begin
            r_lost_count <= {15'd0, w_drop};
         end else if (w_drop && (r_lost_count != 16'hFFFF)) begin
            r_lost_count <= r_lost_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_shift     <= {3'b000, r_mem[r_rd_ptr]};
                  r_idx       <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_hs) begin
                  if (!w_last) begin
                     r_idx   <= r_idx + 3'd1;
                     r_shift <= {8'h00, r_shift[47:8]};
                  end else if (!w_empty) begin
                     // Chain straight into the next record without a bubble.
                     r_shift <= {3'b000, r_mem[r_rd_ptr]};
                     r_idx   <= '0;
                  end else begin
                     r_shift     <= '0;
                     r_idx       <= '0;
                     r_out_valid <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_data   = r_shift[7:0];
   assign out_valid  = r_out_valid;
   assign fifo_level = r_level;
   assign lost_count = r_lost_count;

endmodule
`default_nettype wire

// File: tb/tb_record_byte_streamer.sv
`default_nettype none
// Testbench for record_byte_streamer: record-level queue model feeding a byte
// scoreboard, directed scenarios followed by randomized traffic.
module tb_record_byte_streamer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic          data_rdy   = 1'b0;
   logic [43:0]   data       = '0;
   logic          out_ready  = 1'b0;
   logic          clear_lost = 1'b0;
   logic [7:0]    out_data;
   logic          out_valid;
   logic [AW:0]   fifo_level;
   logic [15:0]   lost_count;

   int total = 0;
   int bad   = 0;

   record_byte_streamer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_rdy   (data_rdy),
      .data       (data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .lost_count (lost_count),
      .clear_lost (clear_lost)
   );

   always #5 clk = ~clk;

   // Reference model: queue of stored records, a record-in-flight byte count,
   // and the expected byte stream.
   logic [44:0] m_q [$];
   logic [7:0]  m_exp [$];
   bit          m_sending = 1'b0;
   int          m_left    = 0;
   bit          m_pending = 1'b0;
   int          m_lc      = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_exp.delete();
         m_sending = 1'b0;
         m_left    = 0;
         m_pending = 1'b0;
         m_lc      = 0;
      end else begin : model_step
         bit          full;
         bit          empty;
         bit          drop;
         bit          pop;
         logic [47:0] w;
         full  = (m_q.size() == DEPTH);
         empty = (m_q.size() == 0);
         drop  = data_rdy && full;
         pop   = !empty && (!m_sending || (out_ready && m_left == 1));
         if (m_sending && out_ready) m_left--;
         if (pop) begin
            w = {3'b000, m_q.pop_front()};
            for (int i = 0; i < 6; i++) m_exp.push_back(w[8*i +: 8]);
            m_sending = 1'b1;
            m_left    = 6;
         end else if (m_sending && m_left == 0) begin
            m_sending = 1'b0;
         end
         if (data_rdy && !full) begin
            m_q.push_back({m_pending, data});
            m_pending = 1'b0;
         end
         if (drop) m_pending = 1'b1;
         if (clear_lost) m_lc = drop ? 1 : 0;
         else if (drop && m_lc < 65535) m_lc++;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         check("out_valid", out_valid, m_sending);
         check("fifo_level", fifo_level, m_q.size());
         check("lost_count", lost_count, m_lc);
         if (out_valid && out_ready) begin
            if (m_exp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
            end else begin
               check("byte", out_data, m_exp.pop_front());
            end
         end
      end
   end

   // Inputs are set at posedge+1 and held through the following edge.
   task automatic step(input bit rdy, input logic [43:0] d, input bit ordy, input bit clr);
      data_rdy   = rdy;
      data       = d;
      out_ready  = ordy;
      clear_lost = clr;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [43:0] rnd44();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[43:0];
   endfunction

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0);
   endtask

   int peak;

   initial begin
      @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset fifo_level", fifo_level, 0);
      check("reset lost_count", lost_count, 0);
      reset_n = 1'b1;
      idle(2, 1'b1);

      // Single record
      step(1'b1, 44'hABC_1234_5678, 1'b1, 1'b0);
      idle(10, 1'b1);
      check("single lost_count", lost_count, 0);

      // Backpressure mid-record
      step(1'b1, rnd44(), 1'b1, 1'b0);
      idle(3, 1'b1);
      idle(5, 1'b0);
      idle(8, 1'b1);

      // Back-to-back records
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, rnd44(), 1'b1, 1'b0);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      for (int i = 0; i < 22; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
      end
      check("b2b peak level", peak, 2);

      // Overflow, then the lost flag on the next kept record
      for (int i = 0; i < 18; i++) step(1'b1, rnd44(), 1'b0, 1'b0);
      check("overflow level", fifo_level, 16);
      check("overflow lost", lost_count, 1);
      idle(17*6 + 10, 1'b1);
      step(1'b1, 44'h123_4567_89AB, 1'b1, 1'b0);
      idle(10, 1'b1);

      // Saturation and clear together with a drop
      for (int i = 0; i < 17; i++) step(1'b1, rnd44(), 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) step(1'b1, rnd44(), 1'b0, 1'b0);
      check("saturated lost", lost_count, 16'hFFFF);
      step(1'b1, rnd44(), 1'b0, 1'b1);
      check("clear with drop", lost_count, 1);
      idle(17*6 + 10, 1'b1);

      // Asynchronous reset in the middle of a record
      for (int i = 0; i < 3; i++) step(1'b1, rnd44(), 1'b1, 1'b0);
      idle(2, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset out_valid", out_valid, 0);
      check("async reset level", fifo_level, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b1, 44'hFED_CBA9_8765, 1'b1, 1'b0);
      idle(10, 1'b1);

      // Randomized traffic with alternating sink speed
      for (int i = 0; i < 3000; i++) begin
         int ready_pct;
         ready_pct = ((i / 500) % 2 == 0) ? 20 : 90;
         step($urandom_range(0, 99) < 40, rnd44(),
              $urandom_range(0, 99) < ready_pct, $urandom_range(0, 99) < 2);
      end
      idle(200, 1'b1);
      check("scoreboard drained", m_exp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
